// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin sequencer in front of the shared combinational 8-bit ALU.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/sel         requester N (N = 0, 1) operand/opcode handshake
//   alu_a, alu_b, alu_sel            registered ALU inputs (held between operations)
//   alu_out, alu_carry               ALU result and carry
//   resp_valid/ready                 response handshake
//   resp_id, resp_data, resp_carry,
//   resp_dz                          tagged response (requester, result, ADD carry, div-by-zero)
//   busy                             an operation is in flight
//   op_count                         completed responses, wraps modulo 2^CNT_W
module alu_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_sel,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_sel,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_carry,
    output logic              resp_dz,

    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [3:0] SelAdd = 4'b0000;
    localparam logic [3:0] SelDiv = 4'b0011;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e              r_state;
    logic                r_last_grant;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [3:0]          r_alu_sel;
    logic                r_resp_valid;
    logic                r_resp_id;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_resp_carry;
    logic                r_resp_dz;
    logic [CNT_W-1:0]    r_op_count;

    logic                w_grant0;
    logic                w_grant1;
    logic                w_div_zero;

    // On a tie the requester that did not win last time is granted; r_last_grant resets to 1
    // so requester 0 wins the first tie.
    always_comb begin
        w_grant0 = req0_valid & (~req1_valid | r_last_grant);
        w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
    end

    assign w_div_zero = (r_alu_sel == SelDiv) && (r_alu_b == '0);

    assign req0_ready = (r_state == StIdle) & w_grant0;
    assign req1_ready = (r_state == StIdle) & w_grant1;
    assign busy       = (r_state != StIdle);

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_carry = r_resp_carry;
    assign resp_dz    = r_resp_dz;
    assign op_count   = r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= '0;
            r_resp_carry <= 1'b0;
            r_resp_dz    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_grant0) begin
                        r_alu_a      <= req0_a;
                        r_alu_b      <= req0_b;
                        r_alu_sel    <= req0_sel;
                        r_resp_id    <= 1'b0;
                        r_last_grant <= 1'b0;
                        r_state      <= StExec;
                    end else if (w_grant1) begin
                        r_alu_a      <= req1_a;
                        r_alu_b      <= req1_b;
                        r_alu_sel    <= req1_sel;
                        r_resp_id    <= 1'b1;
                        r_last_grant <= 1'b1;
                        r_state      <= StExec;
                    end
                end
                StExec: begin
                    // Divide by zero overrides whatever the ALU produced.
                    r_resp_data  <= w_div_zero ? {DATA_W{1'b1}} : alu_out;
                    r_resp_dz    <= w_div_zero;
                    r_resp_carry <= (r_alu_sel == SelAdd) & alu_carry;
                    r_resp_valid <= 1'b1;
                    r_state      <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_op_count   <= r_op_count + CNT_W'(1);
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a bench-side ALU, a transaction-level
// reference model checked every cycle, and literal expectations for each directed vector.
module tb_alu_arbiter;

    localparam int DW = 8;
    localparam int CW = 4;   // small counter so wrap-around is reachable quickly

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]    req0_sel = '0, req1_sel = '0;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [3:0]    alu_sel;
    logic          alu_carry;
    logic          resp_valid, resp_id, resp_carry, resp_dz;
    logic          resp_ready = 1'b1;
    logic [DW-1:0] resp_data;
    logic          busy;
    logic [CW-1:0] op_count;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_carry (resp_carry),
        .resp_dz    (resp_dz),
        .busy       (busy),
        .op_count   (op_count)
    );

    // Shared ALU: 16 operations, carry is always the carry-out of a+b.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
        logic [8:0] sum;
        logic [7:0] y;
        sum = {1'b0, a} + {1'b0, b};
        case (s)
            4'd0:  y = sum[7:0];
            4'd1:  y = a - b;
            4'd2:  y = a * b;
            4'd3:  y = (b == 8'd0) ? 8'h00 : a / b;
            4'd4:  y = a << 1;
            4'd5:  y = a >> 1;
            4'd6:  y = {a[6:0], a[7]};
            4'd7:  y = {a[0], a[7:1]};
            4'd8:  y = a & b;
            4'd9:  y = a | b;
            4'd10: y = a ^ b;
            4'd11: y = ~(a | b);
            4'd12: y = ~(a & b);
            4'd13: y = ~(a ^ b);
            4'd14: y = (a > b) ? 8'd1 : 8'd0;
            default: y = (a == b) ? 8'd1 : 8'd0;
        endcase
        return {sum[8], y};
    endfunction

    always_comb begin
        {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);
    end

    // Response word {id, dz, carry, data}.
    function automatic logic [10:0] mk(input logic id, input logic dz, input logic c,
                                       input logic [7:0] d);
        return {id, dz, c, d};
    endfunction

    // What the response for a transaction must be, from the operation's arithmetic.
    function automatic logic [10:0] spec_resp(input logic id, input logic [7:0] a,
                                              input logic [7:0] b, input logic [3:0] s);
        logic [8:0] r;
        int total;
        r = alu_fn(a, b, s);
        total = int'(a) + int'(b);
        if (s == 4'd3 && b == 8'd0) return mk(id, 1'b1, 1'b0, 8'hFF);
        return mk(id, 1'b0, (s == 4'd0) && (total > 255), r[7:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: at most one transaction in flight; its response becomes visible one
    // cycle after the accepting edge and leaves at the handshake edge.
    bit            m_pend = 0;
    int            m_acc_cyc = 0;
    int            m_last = 1;
    int            m_count = 0;
    logic          m_id = 0;
    logic [7:0]    m_a = 0, m_b = 0;
    logic [3:0]    m_sel = 0;
    logic [10:0]   obs[$];
    int            glog[$];

    always @(negedge clk) begin
        logic er0, er1, show;
        logic [10:0] e;
        if (!rst_n) begin
            m_pend = 0; m_last = 1; m_count = 0;
            m_id = 0; m_a = 0; m_b = 0; m_sel = 0;
            check("rst_busy", busy, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_op_count", op_count, 0);
            check("rst_alu_sel", alu_sel, 0);
        end else begin
            er0 = !m_pend && req0_valid && (!req1_valid || m_last == 1);
            er1 = !m_pend && req1_valid && (!req0_valid || m_last == 0);
            show = m_pend && (cyc - m_acc_cyc >= 1);
            check("req0_ready", req0_ready, er0);
            check("req1_ready", req1_ready, er1);
            check("busy", busy, m_pend);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_sel", alu_sel, m_sel);
            check("op_count", op_count, m_count);
            check("resp_valid", resp_valid, show);
            if (show) begin
                e = spec_resp(m_id, m_a, m_b, m_sel);
                check("resp_word", {resp_id, resp_dz, resp_carry, resp_data}, e);
            end
            if (req0_ready) glog.push_back(0);
            if (req1_ready) glog.push_back(1);
            if (resp_valid && resp_ready) obs.push_back({resp_id, resp_dz, resp_carry, resp_data});
            // Predict the next edge.
            if (er0 || er1) begin
                m_pend = 1; m_acc_cyc = cyc + 1;
                m_id = er1; m_last = er1 ? 1 : 0;
                m_a = er1 ? req1_a : req0_a;
                m_b = er1 ? req1_b : req0_b;
                m_sel = er1 ? req1_sel : req0_sel;
            end else if (show && resp_ready) begin
                m_pend = 0;
                m_count = (m_count + 1) % (1 << CW);
            end
        end
    end

    // One transaction with resp_ready=1; returns the response seen at its handshake and the
    // cycles from the accepting cycle to the first resp_valid cycle.
    task automatic do_txn(input int port, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] s, output logic [10:0] r, output int lat);
        int n0, acc, vis;
        bit got;
        n0 = obs.size(); acc = 0; vis = -1; got = 0;
        @(posedge clk); #1;
        if (port == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_sel = s; end
        else begin req1_valid = 1; req1_a = a; req1_b = b; req1_sel = s; end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk); #1;
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
                got = 1; acc = cyc;
            end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        if (!got) check("accept_timeout", 0, 1);
        for (int i = 0; i < 30 && obs.size() == n0; i++) begin
            @(negedge clk); #1;
            if (resp_valid && vis < 0) vis = cyc;
        end
        if (obs.size() > n0) r = obs[n0];
        else begin r = '0; check("resp_timeout", 0, 1); end
        lat = vis - acc;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [10:0] r;
        int lat, n0, g0;
        bit got;

        repeat (3) @(posedge clk);
        #1;
        check("reset_resp_valid", resp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_resp_data", resp_data, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_op_count", op_count, 0);
        rst_n = 1;

        do_txn(0, 8'h0A, 8'h02, 4'b0000, r, lat);
        check("add_nc_resp", r, mk(0, 0, 0, 8'h0C));
        check("add_nc_latency", lat, 2);
        check("add_nc_count", op_count, 1);

        do_txn(1, 8'hF6, 8'h0A, 4'b0000, r, lat);
        check("add_c_resp", r, mk(1, 0, 1, 8'h00));
        do_txn(1, 8'h33, 8'h33, 4'b1111, r, lat);
        check("eq_resp", r, mk(1, 0, 0, 8'h01));
        do_txn(0, 8'hF0, 8'hF0, 4'b1111, r, lat);
        check("eq_carry_gated", r, mk(0, 0, 0, 8'h01));

        do_txn(0, 8'h10, 8'h00, 4'b0011, r, lat);
        check("div_zero_resp", r, mk(0, 1, 0, 8'hFF));
        do_txn(0, 8'h10, 8'h04, 4'b0011, r, lat);
        check("div_resp", r, mk(0, 0, 0, 8'h04));
        do_txn(1, 8'h05, 8'h07, 4'b0001, r, lat);
        check("sub_resp", r, mk(1, 0, 0, 8'hFE));
        check("count_7", op_count, 7);

        // Backpressure: response held while req1 waits.
        n0 = obs.size();
        resp_ready = 0;
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'hF0; req0_b = 8'h3C; req0_sel = 4'b1000;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk); #1;
            got = req0_ready;
        end
        @(posedge clk); #1;
        req0_valid = 0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk); #1;
            got = resp_valid;
        end
        if (!got) check("bp_resp_timeout", 0, 1);
        @(posedge clk); #1;
        req1_valid = 1; req1_a = 8'h0F; req1_b = 8'hFF; req1_sel = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("bp_resp_valid", resp_valid, 1);
            check("bp_resp_word", {resp_id, resp_dz, resp_carry, resp_data}, mk(0, 0, 0, 8'h30));
            check("bp_req1_ready", req1_ready, 0);
            check("bp_op_count", op_count, 7);
        end
        @(posedge clk); #1;
        resp_ready = 1;
        @(negedge clk); #1;
        check("bp_handshake_ready", req1_ready, 0);
        @(negedge clk); #1;
        check("bp_accept_next_idle", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        for (int i = 0; i < 30 && obs.size() < n0 + 2; i++) begin
            @(negedge clk); #1;
        end
        if (obs.size() >= n0 + 2) begin
            check("bp_first", obs[n0], mk(0, 0, 0, 8'h30));
            check("bp_second", obs[n0 + 1], mk(1, 0, 0, 8'hF0));
        end else check("bp_timeout", 0, 1);
        @(posedge clk); #1;
        check("bp_count", op_count, 9);

        // Reset while the operation is in EXEC.
        @(posedge clk); #1;
        req1_valid = 1; req1_a = 8'h01; req1_b = 8'h01; req1_sel = 4'b0000;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk); #1;
            got = req1_ready;
        end
        @(posedge clk); #1;
        req1_valid = 0;
        check("exec_busy", busy, 1);
        rst_n = 0;
        #1;
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_op_count", op_count, 0);
        check("midrst_alu_sel", alu_sel, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        // Continuous contention from reset: grants alternate starting with req0.
        n0 = obs.size(); g0 = glog.size();
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02; req0_sel = 4'b0000;
        req1_valid = 1; req1_a = 8'h10; req1_b = 8'h20; req1_sel = 4'b0000;
        for (int i = 0; i < 80 && obs.size() < n0 + 4; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        if (obs.size() >= n0 + 4 && glog.size() >= g0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                check("cont_grant", glog[g0 + i], i % 2);
                check("cont_resp", obs[n0 + i], (i % 2 == 0) ? mk(0, 0, 0, 8'h03)
                                                             : mk(1, 0, 0, 8'h30));
            end
        end else check("cont_timeout", 0, 1);
        @(posedge clk); #1;
        check("cont_count", op_count, 4);

        // 12 more completions take a 4-bit counter from 4 to 16, i.e. back to 0.
        for (int i = 0; i < 12; i++) begin
            do_txn(0, 8'(i), 8'h01, 4'b0000, r, lat);
        end
        check("wrap_last_resp", r, mk(0, 0, 0, 8'h0C));
        check("wrap_count", op_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
